sao_clk_div_gen: RTL and testbench

SAO_CLK_DIV_GEN -- requirements
Module: sao_clk_div_gen

---
 rtl/sao_clk_pkg.sv | 13 +
 rtl/sao_clk_div_ch.sv | 73 +++++++
 rtl/sao_clk_div_gen.sv | 46 ++++
 tb/tb_sao_clk_div_gen.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sao_clk_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package sao_clk_pkg;

    localparam int unsigned CNT_W_DEF = 4;

    typedef logic [CNT_W_DEF-1:0] half_t;

    // Half-period saturation: a requested value of 0 behaves as 1.
    function automatic int unsigned half_max1(input int unsigned h);
        return (h == 32'd0) ? 32'd1 : h;
    endfunction

endpackage

// File: rtl/sao_clk_div_ch.sv
// One divider channel: counter, shadow half-period, registered waveform and edge strobes.
module sao_clk_div_ch
    import sao_clk_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] half_i,
    output logic             clk_slow,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic [CNT_W-1:0] hcur_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hs_q, hs_d;
    logic [CNT_W-1:0] half_sat;
    logic             clk_slow_q, clk_slow_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             term;

    // Next state; clr (realign) wins over a coincident toggle and over en.
    always_comb begin
        half_sat   = CNT_W'(half_max1(32'(half_i)));
        term       = (cnt_q == (hs_q - CNT_W'(1)));
        cnt_d      = cnt_q;
        hs_d       = hs_q;
        clk_slow_d = clk_slow_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        if (clr) begin
            cnt_d      = '0;
            clk_slow_d = 1'b0;
            hs_d       = half_sat;
        end else if (en) begin
            if (term) begin
                cnt_d      = '0;
                clk_slow_d = ~clk_slow_q;
                hs_d       = half_sat;
                rise_d     = ~clk_slow_q;
                fall_d     = clk_slow_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            hs_q       <= half_sat;
            clk_slow_q <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            hs_q       <= hs_d;
            clk_slow_q <= clk_slow_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
        end
    end

    assign clk_slow = clk_slow_q;
    assign rise_stb = rise_q;
    assign fall_stb = fall_q;
    assign hcur_o   = hs_q;

endmodule

// File: rtl/sao_clk_div_gen.sv
// NCH independent clock dividers with registered outputs.
// Optional realign input sync_i is present when SAO_CLKGEN_SYNC_EN is defined.
module sao_clk_div_gen
    import sao_clk_pkg::*;
#(
    parameter int unsigned NCH   = 2,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       en,
    input  logic [NCH*CNT_W-1:0] half_i,
`ifdef SAO_CLKGEN_SYNC_EN
    input  logic                 sync_i,
`endif
    output logic [NCH-1:0]       clk_slow,
    output logic [NCH-1:0]       rise_stb,
    output logic [NCH-1:0]       fall_stb,
    output logic [NCH*CNT_W-1:0] hcur_o
);

    logic clr_c;

`ifdef SAO_CLKGEN_SYNC_EN
    assign clr_c = sync_i;
`else
    assign clr_c = 1'b0;
`endif

    for (genvar g = 0; g < int'(NCH); g++) begin : g_ch
        sao_clk_div_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr_c),
            .en       (en[g]),
            .half_i   (half_i[g*CNT_W +: CNT_W]),
            .clk_slow (clk_slow[g]),
            .rise_stb (rise_stb[g]),
            .fall_stb (fall_stb[g]),
            .hcur_o   (hcur_o[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_sao_clk_div_gen.sv
// Directed, table-driven bench for sao_clk_div_gen (NCH=2, CNT_W=4).
// Sync scenario is compiled only when SAO_CLKGEN_SYNC_EN is defined.
module tb_sao_clk_div_gen;

    localparam int unsigned NCH   = 2;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned HW    = NCH * CNT_W;

    logic          clk = 1'b0;
    logic          rst;
    logic [NCH-1:0] en;
    logic [HW-1:0] half_i;
`ifdef SAO_CLKGEN_SYNC_EN
    logic          sync_i;
`endif
    logic [NCH-1:0] clk_slow;
    logic [NCH-1:0] rise_stb;
    logic [NCH-1:0] fall_stb;
    logic [HW-1:0] hcur_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sao_clk_div_gen #(
        .NCH   (NCH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .half_i   (half_i),
`ifdef SAO_CLKGEN_SYNC_EN
        .sync_i   (sync_i),
`endif
        .clk_slow (clk_slow),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .hcur_o   (hcur_o)
    );

    // One record per clk cycle: inputs driven in that cycle, outputs expected in that cycle.
    typedef struct {
        logic       rst;
        logic [1:0] en;
        logic [7:0] half;
        logic       sync;
        logic [1:0] clk_e;
        logic [1:0] rise_e;
        logic [1:0] fall_e;
        logic [7:0] hcur_e;
    } vec_t;

    vec_t vq[$];
    logic [31:0] pc0, pr0, pf0, pc1, pr1, pf1;

    function automatic vec_t mk(input logic r, input logic [1:0] e, input logic [7:0] h,
                                input logic s, input logic [1:0] ce, input logic [1:0] re,
                                input logic [1:0] fe, input logic [7:0] he);
        vec_t v;
        v.rst = r; v.en = e; v.half = h; v.sync = s;
        v.clk_e = ce; v.rise_e = re; v.fall_e = fe; v.hcur_e = he;
        return v;
    endfunction

    task automatic check(input string name, input int cyc, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h required %h", name, cyc, act, exp);
        end
    endtask

    task automatic reset_dut(input logic [7:0] h);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        en     = 2'b11;
        half_i = h;
`ifdef SAO_CLKGEN_SYNC_EN
        sync_i = 1'b0;
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    // Applies the queued vectors from cycle 0 and compares at the falling edge.
    task automatic run_vecs(input string name);
        for (int i = 0; i < vq.size(); i++) begin
            rst    = vq[i].rst;
            en     = vq[i].en;
            half_i = vq[i].half;
`ifdef SAO_CLKGEN_SYNC_EN
            sync_i = vq[i].sync;
`endif
            @(negedge clk);
            check({name, ".clk_slow"}, i, 8'(clk_slow), 8'(vq[i].clk_e));
            check({name, ".rise_stb"}, i, 8'(rise_stb), 8'(vq[i].rise_e));
            check({name, ".fall_stb"}, i, 8'(fall_stb), 8'(vq[i].fall_e));
            check({name, ".hcur_o"},   i, hcur_o,       vq[i].hcur_e);
            @(posedge clk);
            #1;
        end
        vq.delete();
    endtask

    initial begin
        rst    = 1'b1;
        en     = '0;
        half_i = '0;
`ifdef SAO_CLKGEN_SYNC_EN
        sync_i = 1'b0;
`endif

        // Reset state while rst is held: zeros, and hcur tracks max(half_i,1).
        @(posedge clk);
        #1;
        half_i = 8'h50;
        @(posedge clk);
        @(negedge clk);
        check("reset.clk_slow", 0, 8'(clk_slow), 8'h00);
        check("reset.strobes",  0, 8'({rise_stb, fall_stb}), 8'h00);
        check("reset.hcur_o",   0, hcur_o, 8'h51);

        // Basic divide: ch0 H=3, ch1 H=1.
        pc0 = 32'h0000_8E38; pr0 = 32'h0000_8208; pf0 = 32'h0000_1040;
        pc1 = 32'h0000_AAAA; pr1 = 32'h0000_AAAA; pf1 = 32'h0000_5554;
        for (int c = 0; c < 16; c++)
            vq.push_back(mk(1'b0, 2'b11, 8'h13, 1'b0, {pc1[c], pc0[c]}, {pr1[c], pr0[c]},
                            {pf1[c], pf0[c]}, 8'h13));
        reset_dut(8'h13);
        run_vecs("basic");

        // Ratio change: ch0 3 -> 5 requested in cycle 4; ch1 H=2 runs alongside.
        pc0 = 32'h0000_F838; pr0 = 32'h0000_0808; pf0 = 32'h0001_0040;
        pc1 = 32'h0000_CCCC; pr1 = 32'h0000_4444; pf1 = 32'h0001_1110;
        for (int c = 0; c < 17; c++)
            vq.push_back(mk(1'b0, 2'b11, (c < 4) ? 8'h23 : 8'h25, 1'b0,
                            {pc1[c], pc0[c]}, {pr1[c], pr0[c]}, {pf1[c], pf0[c]},
                            (c < 6) ? 8'h23 : 8'h25));
        reset_dut(8'h23);
        run_vecs("ratio");

        // Freeze ch0 over cycles 4..7; ch1 requests H=0 and must behave as H=1.
        pc0 = 32'h0000_23F8; pr0 = 32'h0000_2008; pf0 = 32'h0000_0400;
        pc1 = 32'h0000_2AAA; pr1 = 32'h0000_2AAA; pf1 = 32'h0000_1554;
        for (int c = 0; c < 14; c++)
            vq.push_back(mk(1'b0, (c >= 4 && c <= 7) ? 2'b10 : 2'b11, 8'h03, 1'b0,
                            {pc1[c], pc0[c]}, {pr1[c], pr0[c]}, {pf1[c], pf0[c]}, 8'h13));
        reset_dut(8'h03);
        run_vecs("freeze");

        // Reset pulse in cycle 10 with a new half_i sampled in that same cycle.
        pc0 = 32'h0000_6638; pr0 = 32'h0000_2208; pf0 = 32'h0000_8040;
        pc1 = 32'h0000_82AA; pr1 = 32'h0000_82AA; pf1 = 32'h0000_0554;
        for (int c = 0; c < 16; c++)
            vq.push_back(mk(c == 10, 2'b11, (c < 10) ? 8'h13 : 8'h42, 1'b0,
                            {pc1[c], pc0[c]}, {pr1[c], pr0[c]}, {pf1[c], pf0[c]},
                            (c <= 10) ? 8'h13 : 8'h42));
        reset_dut(8'h13);
        run_vecs("midrst");

`ifdef SAO_CLKGEN_SYNC_EN
        // Sync in cycle 5 coincides with ch0's falling toggle; no strobe, restart.
        pc0 = 32'h0000_0638; pr0 = 32'h0000_0208; pf0 = 32'h0000_0000;
        pc1 = 32'h0000_02AA; pr1 = 32'h0000_02AA; pf1 = 32'h0000_0514;
        for (int c = 0; c < 11; c++)
            vq.push_back(mk(1'b0, 2'b11, 8'h13, c == 5, {pc1[c], pc0[c]},
                            {pr1[c], pr0[c]}, {pf1[c], pf0[c]}, 8'h13));
        reset_dut(8'h13);
        run_vecs("sync");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
